// File: rtl/matmul_pkg.sv
// matmul_pkg: shared state encoding, parameter defaults and dimension check
package matmul_pkg;
    localparam int DATA_WIDTH_DEF = 8;
    localparam int MAX_DIM_DEF = 16;
    localparam int ADDR_WIDTH_DEF = $clog2(MAX_DIM_DEF + 1);
    localparam int ACC_WIDTH_DEF = 2 * DATA_WIDTH_DEF + ADDR_WIDTH_DEF;

    typedef enum logic [2:0] {IDLE, READ, DRAIN, WRITE, DONE} state_t;

    function automatic logic dim_ok(int d, int max_dim);
        return d > 0 && d <= max_dim;
    endfunction
endpackage

// File: rtl/matmul_param_if.sv
// matmul_param_if: control/status handshake and matrix memory ports of matmul_param
interface matmul_param_if import matmul_pkg::*; #(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
);
    logic start, cfg_signed, cfg_sat, busy, done, cfg_error, resultIsInvalid;
    logic [ADDR_WIDTH-1:0] dim_m, dim_k, dim_n;
    logic en_ReadMat_A, en_ReadMat_B, en_WriteMat_C;
    logic [ADDR_WIDTH-1:0] rowAddr_A, colAddr_A, rowAddr_B, colAddr_B, rowAddr_C, colAddr_C;
    logic [DATA_WIDTH-1:0] readData_A, readData_B, writeData_C;

    modport master (
        input start, cfg_signed, cfg_sat, dim_m, dim_k, dim_n, readData_A, readData_B,
        output busy, done, cfg_error, resultIsInvalid, en_ReadMat_A, en_ReadMat_B, en_WriteMat_C,
        output rowAddr_A, colAddr_A, rowAddr_B, colAddr_B, rowAddr_C, colAddr_C, writeData_C
    );
    modport slave (
        output start, cfg_signed, cfg_sat, dim_m, dim_k, dim_n, readData_A, readData_B,
        input busy, done, cfg_error, resultIsInvalid, en_ReadMat_A, en_ReadMat_B, en_WriteMat_C,
        input rowAddr_A, colAddr_A, rowAddr_B, colAddr_B, rowAddr_C, colAddr_C, writeData_C
    );
endinterface

// File: rtl/mac_unit.sv
// mac_unit: signed/unsigned multiply-accumulate with DATA_WIDTH conversion and overflow flag
module mac_unit import matmul_pkg::*; #(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ACC_WIDTH = ACC_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clr,
    input  logic                  add,
    input  logic                  sgn,
    input  logic                  sat,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic [DATA_WIDTH-1:0] res,
    output logic                  ovf
);
    logic [ACC_WIDTH-1:0] acc, a_x, b_x, sum;

    // operands widened to the accumulator so the product and sum never overflow
    assign a_x = {{(ACC_WIDTH-DATA_WIDTH){sgn & a[DATA_WIDTH-1]}}, a};
    assign b_x = {{(ACC_WIDTH-DATA_WIDTH){sgn & b[DATA_WIDTH-1]}}, b};
    assign sum = acc + a_x * b_x;

    // res/ovf describe acc plus the current product, the value acc takes when add is set
    assign ovf = sgn ? sum[ACC_WIDTH-1:DATA_WIDTH-1] != {(ACC_WIDTH-DATA_WIDTH+1){sum[ACC_WIDTH-1]}}
                     : sum[ACC_WIDTH-1:DATA_WIDTH] != '0;
    assign res = !(sat && ovf) ? sum[DATA_WIDTH-1:0]
               : !sgn ? '1 : {sum[ACC_WIDTH-1], {(DATA_WIDTH-1){~sum[ACC_WIDTH-1]}}};

    // accumulator register: clear wins over add
    always_ff @(posedge clk) begin
        if (reset || clr) acc <= '0;
        else if (add) acc <= sum;
    end
endmodule

// File: rtl/matmul_param.sv
// matmul_param: C = A x B over external matrix memories, one MAC per cycle
module matmul_param import matmul_pkg::*; #(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int MAX_DIM = MAX_DIM_DEF
) (
    input logic clk,
    input logic reset,
    matmul_param_if.master bus
);
    localparam int ADDR_WIDTH = $clog2(MAX_DIM + 1);
    localparam int ACC_WIDTH = 2 * DATA_WIDTH + ADDR_WIDTH;

    state_t state;
    logic [ADDR_WIDTH-1:0] m, kd, n, i, j, k, ni, nj;
    logic sgn, sat, legal, last_k, last_j, last_el, mac_clr, mac_add, ovf;
    logic busy, done, cfg_error, invalid, rd_en, wr_en;
    logic [DATA_WIDTH-1:0] res, wdata;

    assign legal = dim_ok(int'(bus.dim_m), MAX_DIM) && dim_ok(int'(bus.dim_k), MAX_DIM)
                && dim_ok(int'(bus.dim_n), MAX_DIM);
    assign last_k = k == kd - 1'b1;
    assign last_j = j == n - 1'b1;
    assign last_el = last_j && i == m - 1'b1;
    assign nj = last_j ? '0 : j + 1'b1;
    assign ni = last_j ? i + 1'b1 : i;
    // the first READ of an element has no returned data yet; DRAIN adds the last product
    assign mac_clr = state == IDLE || state == WRITE;
    assign mac_add = (state == READ && k != '0) || state == DRAIN;

    // addresses come straight from the index registers: A(i,k), B(k,j), C(i,j)
    assign bus.rowAddr_A = i;
    assign bus.colAddr_A = k;
    assign bus.rowAddr_B = k;
    assign bus.colAddr_B = j;
    assign bus.rowAddr_C = i;
    assign bus.colAddr_C = j;
    assign bus.en_ReadMat_A = rd_en;
    assign bus.en_ReadMat_B = rd_en;
    assign bus.en_WriteMat_C = wr_en;
    assign bus.writeData_C = wdata;
    assign bus.busy = busy;
    assign bus.done = done;
    assign bus.cfg_error = cfg_error;
    assign bus.resultIsInvalid = invalid;

    mac_unit #(.DATA_WIDTH(DATA_WIDTH), .ACC_WIDTH(ACC_WIDTH)) u_mac (
        .clk(clk), .reset(reset), .clr(mac_clr), .add(mac_add), .sgn(sgn), .sat(sat),
        .a(bus.readData_A), .b(bus.readData_B), .res(res), .ovf(ovf)
    );

    // control FSM with registered outputs; an illegal config spends one DONE cycle before its pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            {m, kd, n, i, j, k} <= '0;
            {sgn, sat, busy, done, cfg_error, invalid, rd_en, wr_en} <= '0;
            wdata <= '0;
        end else begin
            case (state)
                IDLE: if (bus.start) begin
                    m <= bus.dim_m;
                    kd <= bus.dim_k;
                    n <= bus.dim_n;
                    sgn <= bus.cfg_signed;
                    sat <= bus.cfg_sat;
                    {i, j, k} <= '0;
                    busy <= 1'b1;
                    cfg_error <= 1'b0;
                    invalid <= 1'b0;
                    rd_en <= legal;
                    state <= legal ? READ : DONE;
                end
                READ: begin
                    k <= last_k ? k : k + 1'b1;
                    rd_en <= !last_k;
                    state <= last_k ? DRAIN : READ;
                end
                DRAIN: begin
                    wr_en <= 1'b1;
                    wdata <= res;
                    invalid <= invalid | ovf;
                    state <= WRITE;
                end
                WRITE: begin
                    wr_en <= 1'b0;
                    k <= '0;
                    i <= ni;
                    j <= nj;
                    rd_en <= !last_el;
                    done <= last_el;
                    state <= last_el ? DONE : READ;
                end
                DONE: begin
                    done <= !done;
                    cfg_error <= cfg_error | !done;
                    busy <= !done;
                    state <= done ? IDLE : DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_matmul_param.sv
// tb_matmul_param: table-driven, directed and random checks of matmul_param against a reference model
module tb_matmul_param;
    localparam int DW = 8, MD = 16, AW = $clog2(MD + 1);

    typedef struct {
        int m, kk, n;
        bit sg, st;
        logic [DW-1:0] a, b;
        int c;
        bit inv, err;
    } vec_t;

    logic clk = 1'b0, reset = 1'b1;
    logic [DW-1:0] ma [MD][MD];
    logic [DW-1:0] mb [MD][MD];
    logic [DW-1:0] mc [MD][MD];
    int rd_cnt = 0, wr_cnt = 0, checks = 0, failures = 0;

    always #5 clk = ~clk;

    matmul_param_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus();
    matmul_param #(.DATA_WIDTH(DW), .MAX_DIM(MD)) dut(.clk(clk), .reset(reset), .bus(bus));

    // memory model: reads return one cycle after the request, writes land in mc
    always @(posedge clk) begin
        if (bus.en_ReadMat_A) bus.readData_A <= ma[bus.rowAddr_A][bus.colAddr_A];
        if (bus.en_ReadMat_B) bus.readData_B <= mb[bus.rowAddr_B][bus.colAddr_B];
        if (bus.en_ReadMat_A) rd_cnt <= rd_cnt + 1;
        if (bus.en_WriteMat_C) begin
            mc[bus.rowAddr_C][bus.colAddr_C] <= bus.writeData_C;
            wr_cnt <= wr_cnt + 1;
        end
    end

    function automatic vec_t mk(int m, int kk, int n, bit sg, bit st, logic [DW-1:0] a,
                                logic [DW-1:0] b, int c, bit inv, bit err);
        vec_t v;
        v.m = m; v.kk = kk; v.n = n; v.sg = sg; v.st = st;
        v.a = a; v.b = b; v.c = c; v.inv = inv; v.err = err;
        return v;
    endfunction

    function automatic int sval(logic [DW-1:0] x, bit sg);
        return sg ? int'($signed(x)) : int'(x);
    endfunction

    // golden element: exact dot product, then range check and clamp or wrap; MSB = out of range
    function automatic logic [DW:0] golden(int r, int c, int kk, bit sg, bit st);
        int s = 0;
        int lo, hi;
        for (int t = 0; t < kk; t++) s += sval(ma[r][t], sg) * sval(mb[t][c], sg);
        lo = sg ? -(1 << (DW - 1)) : 0;
        hi = sg ? (1 << (DW - 1)) - 1 : (1 << DW) - 1;
        if (s >= lo && s <= hi) return {1'b0, s[DW-1:0]};
        return {1'b1, !st ? s[DW-1:0] : s < lo ? lo[DW-1:0] : hi[DW-1:0]};
    endfunction

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic fill(logic [DW-1:0] a, logic [DW-1:0] b);
        for (int r = 0; r < MD; r++)
            for (int c = 0; c < MD; c++) begin
                ma[r][c] = a;
                mb[r][c] = b;
            end
    endtask

    // one transaction from a negedge; cyc = edges from start sampling to the edge that sees done
    task automatic run(input int m, kk, n, input bit sg, st, scramble, output int cyc);
        int r0, w0;
        bit err;
        bus.dim_m = AW'(m);
        bus.dim_k = AW'(kk);
        bus.dim_n = AW'(n);
        bus.cfg_signed = sg;
        bus.cfg_sat = st;
        bus.start = 1'b1;
        r0 = rd_cnt;
        w0 = wr_cnt;
        err = m < 1 || m > MD || kk < 1 || kk > MD || n < 1 || n > MD;
        cyc = 0;
        @(posedge clk);
        do begin
            @(negedge clk);
            cyc++;
            bus.start = scramble && cyc < 5;
            if (scramble) begin
                bus.dim_m = 1; bus.dim_k = 1; bus.dim_n = 1;
                bus.cfg_signed = !sg; bus.cfg_sat = !st;
            end
        end while (!bus.done && cyc < 6000);
        chk("done_latency", cyc, err ? 2 : m * n * (kk + 2) + 1);
        chk("cfg_error", bus.cfg_error, err);
        @(negedge clk);
        chk("reads", rd_cnt - r0, err ? 0 : m * n * kk);
        chk("writes", wr_cnt - w0, err ? 0 : m * n);
        chk("done_busy_after", {bus.done, bus.busy}, 0);
    endtask

    task automatic two_by_two();
        int cyc;
        ma[0][0] = 1; ma[0][1] = 2; ma[1][0] = 3; ma[1][1] = 4;
        mb[0][0] = 5; mb[0][1] = 6; mb[1][0] = 7; mb[1][1] = 8;
        run(2, 2, 2, 1'b0, 1'b0, 1'b0, cyc);
        chk("c2x2_00", mc[0][0], 19);
        chk("c2x2_01", mc[0][1], 22);
        chk("c2x2_10", mc[1][0], 43);
        chk("c2x2_11", mc[1][1], 50);
        chk("c2x2_inv", bus.resultIsInvalid, 0);
    endtask

    task automatic rand_run(input int m, kk, n, input bit scramble);
        bit sg, st, inv_any;
        int cyc;
        logic [DW:0] g;
        sg = 1'($urandom);
        st = 1'($urandom);
        for (int r = 0; r < MD; r++)
            for (int c = 0; c < MD; c++) begin
                ma[r][c] = DW'($urandom);
                mb[r][c] = DW'($urandom);
            end
        run(m, kk, n, sg, st, scramble, cyc);
        inv_any = 1'b0;
        for (int r = 0; r < m; r++)
            for (int c = 0; c < n; c++) begin
                g = golden(r, c, kk, sg, st);
                inv_any |= g[DW];
                chk($sformatf("rand_c[%0d][%0d]", r, c), mc[r][c], g[DW-1:0]);
            end
        chk("rand_inv", bus.resultIsInvalid, inv_any);
    endtask

    initial begin
        vec_t tv[$];
        int cyc, w0;
        bit done_seen;
        bus.start = 1'b0;
        bus.dim_m = '0; bus.dim_k = '0; bus.dim_n = '0;
        bus.cfg_signed = 1'b0; bus.cfg_sat = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_flags", {bus.busy, bus.done, bus.cfg_error, bus.resultIsInvalid,
                            bus.en_ReadMat_A, bus.en_ReadMat_B, bus.en_WriteMat_C}, 0);
        reset = 1'b0;
        @(negedge clk);

        tv.push_back(mk(1, 4, 1, 0, 1, 8'd10, 8'd10, 255, 1, 0));
        tv.push_back(mk(1, 4, 1, 0, 0, 8'd10, 8'd10, 144, 1, 0));
        tv.push_back(mk(1, 1, 1, 1, 1, 8'h80, 8'hFF, 8'h7F, 1, 0));
        tv.push_back(mk(1, 1, 1, 1, 1, 8'hFD, 8'h05, 8'hF1, 0, 0));
        tv.push_back(mk(1, 1, 1, 1, 0, 8'h80, 8'hFF, 8'h80, 1, 0));
        tv.push_back(mk(1, 1, 1, 0, 1, 8'hFF, 8'h01, 255, 0, 0));
        tv.push_back(mk(1, 16, 1, 1, 1, 8'h80, 8'h80, 8'h7F, 1, 0));
        tv.push_back(mk(1, 16, 1, 1, 1, 8'h80, 8'h7F, 8'h80, 1, 0));
        tv.push_back(mk(2, 0, 2, 0, 0, 8'd1, 8'd1, -1, 0, 1));
        tv.push_back(mk(17, 2, 2, 0, 0, 8'd1, 8'd1, -1, 0, 1));
        tv.push_back(mk(3, 3, 0, 0, 0, 8'd1, 8'd1, -1, 0, 1));
        foreach (tv[t]) begin
            fill(tv[t].a, tv[t].b);
            run(tv[t].m, tv[t].kk, tv[t].n, tv[t].sg, tv[t].st, 1'b0, cyc);
            chk($sformatf("vec%0d_inv", t), bus.resultIsInvalid, tv[t].inv);
            if (tv[t].c >= 0) chk($sformatf("vec%0d_c", t), mc[0][0], tv[t].c);
        end

        two_by_two();
        for (int r = 0; r < 4; r++)
            rand_run($urandom_range(1, 5), $urandom_range(1, 6), $urandom_range(1, 5), 1'b0);
        rand_run(16, 16, 16, 1'b1);

        // reset during the third element of an overflowing 2x2x2 run
        fill(8'd200, 8'd200);
        bus.dim_m = 2; bus.dim_k = 2; bus.dim_n = 2;
        bus.cfg_signed = 1'b0; bus.cfg_sat = 1'b1; bus.start = 1'b1;
        w0 = wr_cnt;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        for (int t = 0; t < 100 && wr_cnt - w0 < 2; t++) @(negedge clk);
        chk("wait_two_writes", wr_cnt - w0, 2);
        chk("sat_value_before_reset", bus.writeData_C, 255);
        chk("inv_before_reset", bus.resultIsInvalid, 1);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rst_flags", {bus.busy, bus.done, bus.cfg_error, bus.resultIsInvalid,
                          bus.en_ReadMat_A, bus.en_ReadMat_B, bus.en_WriteMat_C}, 0);
        chk("rst_addr", {bus.rowAddr_A, bus.colAddr_A, bus.rowAddr_B, bus.colAddr_B,
                         bus.rowAddr_C, bus.colAddr_C}, 0);
        chk("rst_wdata", bus.writeData_C, 0);
        reset = 1'b0;
        done_seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            done_seen |= bus.done;
        end
        chk("no_write_after_reset", wr_cnt - w0, 2);
        chk("no_done_after_reset", done_seen, 0);
        two_by_two();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
